// File: rtl/spi_keycode_slave_if.sv
// spi_keycode_slave_if: SPI pin bundle between an external master and the keycode slave.
// Ports: SPI_SCLK, SPI_SS_N, SPI_MOSI (master to slave); SPI_MISO, SPI_MISO_OE (slave to master).
interface spi_keycode_slave_if;
  logic SPI_SCLK;
  logic SPI_SS_N;
  logic SPI_MOSI;
  logic SPI_MISO;
  logic SPI_MISO_OE;
  modport master (output SPI_SCLK, SPI_SS_N, SPI_MOSI, input SPI_MISO, SPI_MISO_OE);
  modport slave (input SPI_SCLK, SPI_SS_N, SPI_MOSI, output SPI_MISO, SPI_MISO_OE);
endinterface

// File: rtl/spi_keycode_slave.sv
// spi_keycode_slave: oversampled SPI mode-0 slave that commits FRAME_BYTES-byte keycode frames on SS_N rise.
// Ports: Clk/Reset (sync, active high); spi (slave modport of SPI pins); status_byte returned as first MISO byte;
// keycode (byte 0 in MSBs), keycode_valid and frame_err are one-Clk pulses at frame end.
module spi_keycode_slave #(
  parameter int FRAME_BYTES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  spi_keycode_slave_if.slave       spi,
  input  logic [7:0]               status_byte,
  output logic [8*FRAME_BYTES-1:0] keycode,
  output logic                     keycode_valid,
  output logic                     frame_err
);
  localparam int BW = $clog2(FRAME_BYTES + 1);
  localparam logic [BW-1:0] FULL = BW'(FRAME_BYTES);
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_d, ss_d;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [7:0] rx_shift, tx_shift;
  logic [2:0] bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic overrun, oe;
  logic [8*FRAME_BYTES-1:0] frame_buf;
  logic [7:0] rx_next;
  assign rx_next = {rx_shift[6:0], mosi_sync[SYNC_STAGES-1]};
  assign spi.SPI_MISO_OE = oe;
  assign spi.SPI_MISO = oe & tx_shift[7];
  // Edge flags are registered so every pin event is acted on SYNC_STAGES+2 Clk after it happens.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ss_fall   <= 1'b0;
      ss_rise   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SPI_SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.SPI_SS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.SPI_MOSI};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
      sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_d;
      ss_fall   <= ~ss_sync[SYNC_STAGES-1] & ss_d;
      ss_rise   <= ss_sync[SYNC_STAGES-1] & ~ss_d;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= WAIT_IDLE;
      rx_shift      <= '0;
      tx_shift      <= '0;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      overrun       <= 1'b0;
      oe            <= 1'b0;
      frame_buf     <= '0;
      keycode       <= '0;
      keycode_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      keycode_valid <= 1'b0;
      frame_err     <= 1'b0;
      case (state)
        WAIT_IDLE: if (ss_sync[SYNC_STAGES-1]) state <= IDLE;
        IDLE: if (ss_fall) begin
          tx_shift <= status_byte;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          overrun  <= 1'b0;
          oe       <= 1'b1;
          state    <= ACTIVE;
        end
        ACTIVE: if (ss_rise) begin
          state <= IDLE;
          oe    <= 1'b0;
          if (byte_cnt == FULL && bit_cnt == 3'd0 && !overrun) begin
            keycode       <= frame_buf;
            keycode_valid <= 1'b1;
          end else frame_err <= 1'b1;
        end else if (sclk_rise) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            // Shifting bytes in from the right leaves byte 0 in the MSBs once the frame is full.
            if (byte_cnt < FULL) begin
              frame_buf <= {frame_buf[8*FRAME_BYTES-9:0], rx_next};
              byte_cnt  <= byte_cnt + BW'(1);
            end else overrun <= 1'b1;
          end
        end else if (sclk_fall) tx_shift <= bit_cnt == 3'd0 ? rx_shift : {tx_shift[6:0], 1'b0};
        default: state <= WAIT_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_keycode_slave.sv
// tb_spi_keycode_slave: randomized and directed self-checking bench for spi_keycode_slave.
`timescale 1ns/1ps
module tb_spi_keycode_slave;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [7:0] status_byte = 8'h00;
  logic [31:0] keycode;
  logic keycode_valid, frame_err;
  int total = 0, bad = 0;
  int vcount = 0, ecount = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [31:0] exp_key = 32'h0;
  spi_keycode_slave_if spi();
  spi_keycode_slave #(.FRAME_BYTES(4), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset(Reset), .spi(spi), .status_byte(status_byte),
    .keycode(keycode), .keycode_valid(keycode_valid), .frame_err(frame_err)
  );
  always #10 Clk = ~Clk;
  always @(negedge Clk) begin
    vcount += int'(keycode_valid);
    ecount += int'(frame_err);
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask
  task automatic send_frame(input int nbits, input int rst_at);
    logic [7:0] cur, b;
    cur = 8'h00;
    rx_q.delete();
    spi.SPI_SS_N = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
      end
      b = tx_q[i/8];
      spi.SPI_MOSI = b[7 - i%8];
      tick(8);
      cur = {cur[6:0], spi.SPI_MISO};
      if (i % 8 == 7) rx_q.push_back(cur);
      spi.SPI_SCLK = 1'b1;
      tick(8);
      spi.SPI_SCLK = 1'b0;
    end
    tick(8);
    spi.SPI_SS_N = 1'b1;
  endtask
  task automatic load(input logic [7:0] b0, b1, b2, b3, b4);
    tx_q = '{b0, b1, b2, b3, b4};
  endtask
  task automatic test_reset;
    Reset = 1'b1;
    tick(3);
    total++; if (keycode !== 32'h0) begin bad++; $display("FAIL reset_keycode got=%h exp=0", keycode); end
    total++; if ({keycode_valid, frame_err} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {keycode_valid, frame_err}); end
    total++; if ({spi.SPI_MISO, spi.SPI_MISO_OE} !== 2'b00) begin bad++; $display("FAIL reset_miso got=%b exp=00", {spi.SPI_MISO, spi.SPI_MISO_OE}); end
    Reset = 1'b0;
    tick(8);
  endtask
  task automatic test_basic;
    int v0, e0, n;
    v0 = vcount; e0 = ecount;
    load(8'h1A, 8'h00, 8'h00, 8'h07, 8'h00);
    send_frame(32, -1);
    n = 0;
    while (n < 20 && keycode_valid !== 1'b1) begin
      tick(1);
      n++;
    end
    total++; if (n !== 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", n); end
    tick(1);
    total++; if (keycode_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse_width got=%b exp=0", keycode_valid); end
    tick(6);
    exp_key = 32'h1A000007;
    total++; if (keycode !== exp_key) begin bad++; $display("FAIL basic_keycode got=%h exp=%h", keycode, exp_key); end
    total++; if (vcount - v0 !== 1 || ecount - e0 !== 0) begin bad++; $display("FAIL basic_counts got=%0d/%0d exp=1/0", vcount - v0, ecount - e0); end
  endtask
  task automatic test_malformed;
    int v0, e0;
    v0 = vcount; e0 = ecount;
    load(8'h55, 8'h66, 8'h77, 8'h88, 8'h99);
    send_frame(24, -1); tick(10);
    send_frame(40, -1); tick(10);
    send_frame(35, -1); tick(10);
    total++; if (ecount - e0 !== 3) begin bad++; $display("FAIL malformed_err got=%0d exp=3", ecount - e0); end
    total++; if (vcount - v0 !== 0) begin bad++; $display("FAIL malformed_valid got=%0d exp=0", vcount - v0); end
    total++; if (keycode !== exp_key) begin bad++; $display("FAIL malformed_keycode got=%h exp=%h", keycode, exp_key); end
  endtask
  task automatic test_echo;
    int v0;
    v0 = vcount;
    status_byte = 8'hA5;
    load(8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
    total++; if (spi.SPI_MISO_OE !== 1'b0) begin bad++; $display("FAIL echo_oe_before got=%b exp=0", spi.SPI_MISO_OE); end
    send_frame(32, -1);
    tick(10);
    total++; if (spi.SPI_MISO_OE !== 1'b0) begin bad++; $display("FAIL echo_oe_after got=%b exp=0", spi.SPI_MISO_OE); end
    total++; if (rx_q.size() !== 4) begin bad++; $display("FAIL echo_count got=%0d exp=4", rx_q.size()); end
    else for (int k = 0; k < 4; k++) begin
      total++; if (rx_q[k] !== (k == 0 ? 8'hA5 : tx_q[k-1])) begin bad++; $display("FAIL echo_byte%0d got=%h exp=%h", k, rx_q[k], k == 0 ? 8'hA5 : tx_q[k-1]); end
    end
    exp_key = 32'h11223344;
    total++; if (keycode !== exp_key || vcount - v0 !== 1) begin bad++; $display("FAIL echo_keycode got=%h/%0d exp=%h/1", keycode, vcount - v0, exp_key); end
  endtask
  task automatic test_sclk_noise;
    int v0, e0;
    v0 = vcount; e0 = ecount;
    for (int i = 0; i < 20; i++) begin
      spi.SPI_SCLK = ~spi.SPI_SCLK;
      tick(8);
    end
    spi.SPI_SCLK = 1'b0;
    tick(8);
    load(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00);
    send_frame(32, -1);
    tick(10);
    exp_key = 32'hDEADBEEF;
    total++; if (vcount - v0 !== 1 || ecount - e0 !== 0) begin bad++; $display("FAIL noise_counts got=%0d/%0d exp=1/0", vcount - v0, ecount - e0); end
    total++; if (keycode !== exp_key) begin bad++; $display("FAIL noise_keycode got=%h exp=%h", keycode, exp_key); end
  endtask
  task automatic test_reset_mid;
    int v0, e0;
    v0 = vcount; e0 = ecount;
    load(8'h12, 8'h34, 8'h56, 8'h78, 8'h00);
    send_frame(32, 16);
    tick(10);
    exp_key = 32'h0;
    total++; if (vcount - v0 !== 0 || ecount - e0 !== 0) begin bad++; $display("FAIL midreset_pulses got=%0d/%0d exp=0/0", vcount - v0, ecount - e0); end
    total++; if (keycode !== exp_key) begin bad++; $display("FAIL midreset_keycode got=%h exp=%h", keycode, exp_key); end
    load(8'h00, 8'h00, 8'h00, 8'h04, 8'h00);
    send_frame(32, -1);
    tick(10);
    exp_key = 32'h00000004;
    total++; if (keycode !== exp_key || vcount - v0 !== 1) begin bad++; $display("FAIL midreset_next got=%h/%0d exp=%h/1", keycode, vcount - v0, exp_key); end
  endtask
  task automatic test_random;
    int v0, e0, nbits, nb;
    logic ok;
    for (int r = 0; r < 8; r++) begin
      v0 = vcount; e0 = ecount;
      status_byte = 8'($urandom);
      load(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      case ($urandom_range(0, 4))
        0: nbits = 24;
        1: nbits = 40;
        2: nbits = 32 + int'($urandom_range(1, 7));
        default: nbits = 32;
      endcase
      send_frame(nbits, -1);
      tick(10);
      ok = (nbits == 32);
      if (ok) exp_key = {tx_q[0], tx_q[1], tx_q[2], tx_q[3]};
      total++; if (keycode !== exp_key) begin bad++; $display("FAIL rand%0d_keycode got=%h exp=%h", r, keycode, exp_key); end
      total++; if (vcount - v0 !== int'(ok) || ecount - e0 !== int'(!ok)) begin bad++; $display("FAIL rand%0d_counts got=%0d/%0d exp=%0d/%0d", r, vcount - v0, ecount - e0, int'(ok), int'(!ok)); end
      nb = nbits / 8;
      total++; if (rx_q.size() !== nb) begin bad++; $display("FAIL rand%0d_misocount got=%0d exp=%0d", r, rx_q.size(), nb); end
      else for (int k = 0; k < nb; k++) begin
        total++; if (rx_q[k] !== (k == 0 ? status_byte : tx_q[k-1])) begin bad++; $display("FAIL rand%0d_miso%0d got=%h exp=%h", r, k, rx_q[k], k == 0 ? status_byte : tx_q[k-1]); end
      end
    end
  endtask
  initial begin
    spi.SPI_SCLK = 1'b0;
    spi.SPI_SS_N = 1'b1;
    spi.SPI_MOSI = 1'b0;
    test_reset;
    test_basic;
    test_malformed;
    test_echo;
    test_sclk_noise;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
